// File: rtl/pito_loader_pkg.sv
// Shared types and constants for the pito memory loader.
// The run-phase timeout is enabled by defining PITO_LOADER_TIMEOUT_EN.
package pito_loader_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned EXIT_W = 31;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      RDWAIT = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic SEL_IMEM = 1'b0;
   localparam logic SEL_DMEM = 1'b1;

   localparam logic [11:0] DEFAULT_TOHOST_ADDR = 12'hFFF;

endpackage

// File: rtl/pito_loader_timer.sv
// Run-phase cycle counter; expired flags the last permitted RUN cycle.
module pito_loader_timer #(
   parameter int unsigned LIMIT = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = 32;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + CNT_W'(1);
   end

   assign expired = en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/pito_mem_loader.sv
// Host-side loader for a pito core: backdoor memory access, core release and tohost completion.
// Optional run-phase timeout is compiled in with PITO_LOADER_TIMEOUT_EN.
module pito_mem_loader
   import pito_loader_pkg::*;
#(
   parameter int unsigned          ADDR_W         = 12,
   parameter logic [ADDR_W-1:0]    TOHOST_ADDR    = ADDR_W'(DEFAULT_TOHOST_ADDR),
   parameter int unsigned          TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                host_valid,
   output logic                host_ready,
   input  logic                host_we,
   input  logic                host_sel,
   input  logic [ADDR_W-1:0]   host_addr,
   input  logic [DATA_W-1:0]   host_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   input  logic                start,
   output logic                core_rst_n,
   output logic                mem_we,
   output logic                mem_sel,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                core_dmem_we,
   input  logic [ADDR_W-1:0]   core_dmem_addr,
   input  logic [DATA_W-1:0]   core_dmem_wdata,
   output logic                done,
   output logic [EXIT_W-1:0]   exit_code,
   output logic                timeout
);

   state_t              state, state_nxt;
   logic                ret_done, ret_done_nxt;
   logic                done_nxt, timeout_nxt;
   logic [EXIT_W-1:0]   exit_nxt;
   logic                start_acc;
   logic                tohost_hit;
   logic                tmr_expired;

   assign tohost_hit = core_dmem_we && (core_dmem_addr == TOHOST_ADDR) && core_dmem_wdata[0];

`ifdef PITO_LOADER_TIMEOUT_EN
   pito_loader_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (start_acc),
      .en      (state == RUN),
      .expired (tmr_expired)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign tmr_expired        = 1'b0;
`endif

   // State and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         ret_done  <= 1'b0;
         done      <= 1'b0;
         exit_code <= '0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         ret_done  <= ret_done_nxt;
         done      <= done_nxt;
         exit_code <= exit_nxt;
         timeout   <= timeout_nxt;
      end
   end

   // Next state, memory port and status updates
   always_comb begin
      state_nxt    = state;
      ret_done_nxt = ret_done;
      done_nxt     = done;
      exit_nxt     = exit_code;
      timeout_nxt  = timeout;
      start_acc    = 1'b0;
      mem_we       = 1'b0;
      mem_sel      = host_sel;
      mem_addr     = host_addr;
      mem_wdata    = host_wdata;
      case (state)
         LOAD, DONE: begin
            if (host_valid) begin
               if (host_we) begin
                  mem_we = 1'b1;
               end else begin
                  state_nxt    = RDWAIT;
                  ret_done_nxt = (state == DONE);
               end
            end else if (start) begin
               start_acc   = 1'b1;
               state_nxt   = RUN;
               done_nxt    = 1'b0;
               exit_nxt    = '0;
               timeout_nxt = 1'b0;
            end
         end
         RDWAIT: begin
            state_nxt = ret_done ? DONE : LOAD;
         end
         RUN: begin
            // A real completion beats a coincident timeout
            if (tohost_hit) begin
               state_nxt   = DONE;
               done_nxt    = 1'b1;
               exit_nxt    = core_dmem_wdata[DATA_W-1:1];
               timeout_nxt = 1'b0;
            end else if (tmr_expired) begin
               state_nxt   = DONE;
               done_nxt    = 1'b1;
               exit_nxt    = '0;
               timeout_nxt = 1'b1;
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Decodes of the state register
   assign host_ready = (state == LOAD) || (state == DONE);
   assign core_rst_n = (state == RUN);
   assign rsp_valid  = (state == RDWAIT);
   assign rsp_data   = rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_pito_mem_loader.sv
// Scoreboard bench for pito_mem_loader; read responses are checked against queued expectations.
module tb_pito_mem_loader;
   import pito_loader_pkg::*;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned TCYC   = 16;

   logic              clk, rst_n;
   logic              host_valid, host_ready, host_we, host_sel;
   logic [ADDR_W-1:0] host_addr;
   logic [31:0]       host_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_data;
   logic              start, core_rst_n;
   logic              mem_we, mem_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;
   logic              core_dmem_we;
   logic [ADDR_W-1:0] core_dmem_addr;
   logic [31:0]       core_dmem_wdata;
   logic              done, timeout;
   logic [30:0]       exit_code;

   pito_mem_loader #(
      .ADDR_W         (ADDR_W),
      .TOHOST_ADDR    (12'hFFF),
      .TIMEOUT_CYCLES (TCYC)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .host_valid      (host_valid),
      .host_ready      (host_ready),
      .host_we         (host_we),
      .host_sel        (host_sel),
      .host_addr       (host_addr),
      .host_wdata      (host_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .start           (start),
      .core_rst_n      (core_rst_n),
      .mem_we          (mem_we),
      .mem_sel         (mem_sel),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .core_dmem_we    (core_dmem_we),
      .core_dmem_addr  (core_dmem_addr),
      .core_dmem_wdata (core_dmem_wdata),
      .done            (done),
      .exit_code       (exit_code),
      .timeout         (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backdoor memories with one-cycle read latency
   logic [31:0] imem [4096];
   logic [31:0] dmem [4096];
   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_sel == SEL_DMEM) dmem[mem_addr] <= mem_wdata;
         else                     imem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= (mem_sel == SEL_DMEM) ? dmem[mem_addr] : imem[mem_addr];
   end

   int          vectors = 0;
   int          miscompares = 0;
   int          rsp_seen = 0;
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         rsp_seen++;
         if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
         else                   chk("rsp_data", rsp_data, exp_q.pop_front());
      end
   end

   task automatic idle();
      host_valid = 1'b0; host_we = 1'b0; host_sel = 1'b0;
      host_addr = '0; host_wdata = '0; start = 1'b0;
      core_dmem_we = 1'b0; core_dmem_addr = '0; core_dmem_wdata = '0;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic host_wr(input logic sel, input logic [ADDR_W-1:0] a, input logic [31:0] d);
      host_valid = 1'b1; host_we = 1'b1; host_sel = sel; host_addr = a; host_wdata = d;
      @(negedge clk);
      chk("wr_mem_we", 32'(mem_we), 32'd1);
      chk("wr_mem_addr", 32'(mem_addr), 32'(a));
      chk("wr_mem_wdata", mem_wdata, d);
      cyc(); idle();
   endtask

   task automatic host_rd(input logic sel, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
      host_valid = 1'b1; host_we = 1'b0; host_sel = sel; host_addr = a;
      @(negedge clk);
      chk("rd_mem_we", 32'(mem_we), 32'd0);
      chk("rd_mem_addr", 32'(mem_addr), 32'(a));
      exp_q.push_back(exp);
      cyc(); idle();
   endtask

   task automatic core_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      core_dmem_we = 1'b1; core_dmem_addr = a; core_dmem_wdata = d;
      cyc(); idle();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(); idle();
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_host_ready"}, 32'(host_ready), 32'd1);
      chk({pfx, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
      chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({pfx, "_rsp_data"}, rsp_data, 32'd0);
      chk({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({pfx, "_done"}, 32'(done), 32'd0);
      chk({pfx, "_exit_code"}, 32'(exit_code), 32'd0);
      chk({pfx, "_timeout"}, 32'(timeout), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst_n = 1'b1;
      cyc();

      // Image load and readback
      for (int i = 0; i < 4; i++) host_wr(SEL_IMEM, ADDR_W'(i), 32'h0000_0013);
      host_wr(SEL_DMEM, 12'd5, 32'hABCD_1234);
      host_rd(SEL_IMEM, 12'd2, 32'h0000_0013);
      chk("rdwait_ready", 32'(host_ready), 32'd0);
      chk("rdwait_rsp_valid", 32'(rsp_valid), 32'd1);
      cyc();
      chk("rd_ret_ready", 32'(host_ready), 32'd1);
      chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);

      // Start coincident with a read is ignored
      start = 1'b1;
      host_rd(SEL_DMEM, 12'd5, 32'hABCD_1234);
      chk("coinc_core_rst_n", 32'(core_rst_n), 32'd0);
      cyc();
      chk("coinc_not_run", 32'(host_ready), 32'd1);
      chk("coinc_core_rst_n2", 32'(core_rst_n), 32'd0);

      // Release core, ignore non-completing writes, then complete
      start = 1'b1;
      @(negedge clk);
      chk("start_same_cycle", 32'(core_rst_n), 32'd0);
      cyc(); idle();
      chk("run_core_rst_n", 32'(core_rst_n), 32'd1);
      chk("run_ready", 32'(host_ready), 32'd0);
      host_valid = 1'b1; host_we = 1'b1; host_addr = 12'd7;
      @(negedge clk);
      chk("run_host_blocked", 32'(mem_we), 32'd0);
      cyc(); idle();
      core_wr(12'hFFE, 32'h0000_0003);
      chk("other_addr_ignored", 32'(done), 32'd0);
      core_wr(12'hFFF, 32'h0000_0001);
      chk("done1", 32'(done), 32'd1);
      chk("exit1", 32'(exit_code), 32'd0);
      chk("done1_core_rst_n", 32'(core_rst_n), 32'd0);
      chk("done1_ready", 32'(host_ready), 32'd1);

      // Restart from DONE; even tohost value is not a completion
      pulse_start();
      chk("restart_done_clr", 32'(done), 32'd0);
      core_wr(12'hFFF, 32'h0000_002A);
      chk("even_ignored", 32'(done), 32'd0);
      chk("even_core_rst_n", 32'(core_rst_n), 32'd1);
      core_wr(12'hFFF, 32'h0000_0055);
      chk("done2", 32'(done), 32'd1);
      chk("exit2", 32'(exit_code), 32'h0000_002A);

      // Read from DONE returns to DONE
      host_rd(SEL_IMEM, 12'd0, 32'h0000_0013);
      cyc();
      chk("done_rd_ready", 32'(host_ready), 32'd1);
      chk("done_held", 32'(done), 32'd1);
      chk("exit_held", 32'(exit_code), 32'h0000_002A);

`ifdef PITO_LOADER_TIMEOUT_EN
      pulse_start();
      for (int k = 1; k <= int'(TCYC); k++) begin
         cyc();
         if (k == int'(TCYC) - 1) chk("to_early", 32'(done), 32'd0);
      end
      chk("to_done", 32'(done), 32'd1);
      chk("to_flag", 32'(timeout), 32'd1);
      chk("to_exit", 32'(exit_code), 32'd0);
      chk("to_core_rst_n", 32'(core_rst_n), 32'd0);
`else
      pulse_start();
      repeat (40) cyc();
      chk("no_to_done", 32'(done), 32'd0);
      chk("no_to_flag", 32'(timeout), 32'd0);
      chk("no_to_run", 32'(core_rst_n), 32'd1);
      core_wr(12'hFFF, 32'h0000_0003);
      chk("done3", 32'(done), 32'd1);
      chk("exit3", 32'(exit_code), 32'd1);
`endif

      // Reset during RDWAIT aborts the response
      host_valid = 1'b1; host_we = 1'b0; host_sel = SEL_IMEM; host_addr = 12'd1;
      cyc(); idle();
      seen = rsp_seen;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      exp_q.delete();
      repeat (2) cyc();
      chk("abort_no_rsp", 32'(rsp_seen), 32'(seen));
      rst_n = 1'b1;
      cyc();

      chk("rsp_count", 32'(rsp_seen), 32'd3);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
